// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: runs a latched (steps, dir, div) move over a one-hot
// phase position that persists between moves, with start/busy/done/abort handshake.
module stepper_move_ctrl #(
    parameter int PHASES = 9,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [CNT_W-1:0]  steps_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              step_pulse_o,
    output logic [PHASES-1:0] phase_o,
    output logic [3:0]        pos_o
);

    // state  | meaning
    // S_IDLE | holding position, waiting for start
    // S_RUN  | move in progress, stepping every div+1 cycles
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [3:0]        POS_LAST  = 4'(PHASES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [DIV_W-1:0]  DIV_ONE   = 1;
    localparam logic [PHASES-1:0] PHASE_RST = 1;

    state_t            state_q;
    logic              dir_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  tick_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [3:0]        pos_q, pos_d;
    logic [PHASES-1:0] phase_q, phase_d;
    logic              busy_q, done_q, step_pulse_q;

    // Next position with wrap in both directions; phase is its one-hot decode.
    always_comb begin
        pos_d = pos_q;
        if (dir_q) begin
            pos_d = (pos_q == POS_LAST) ? 4'd0 : pos_q + 4'd1;
        end else begin
            pos_d = (pos_q == 4'd0) ? POS_LAST : pos_q - 4'd1;
        end
        phase_d        = '0;
        phase_d[pos_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            div_q        <= '0;
            tick_q       <= '0;
            remaining_q  <= '0;
            pos_q        <= 4'd0;
            phase_q      <= PHASE_RST;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (steps_i != '0) begin
                            dir_q       <= dir_i;
                            div_q       <= div_i;
                            remaining_q <= steps_i;
                            tick_q      <= '0;
                            state_q     <= S_RUN;
                            busy_q      <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Abort wins over a coincident step, including the last one.
                    if (abort_i) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        tick_q      <= '0;
                        remaining_q <= '0;
                    end else if (tick_q == div_q) begin
                        tick_q       <= '0;
                        pos_q        <= pos_d;
                        phase_q      <= phase_d;
                        remaining_q  <= remaining_q - CNT_ONE;
                        step_pulse_q <= 1'b1;
                        if (remaining_q == CNT_ONE) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + DIV_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign step_pulse_o = step_pulse_q;
    assign phase_o      = phase_q;
    assign pos_o        = pos_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Self-checking bench for stepper_move_ctrl: directed and random moves compared
// against a closed-form trajectory model (position = start + dir * floor(k/(div+1))).
module tb_stepper_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, dir, abort;
    logic [7:0] steps, div;
    logic       busy, done, step_pulse;
    logic [8:0] phase;
    logic [3:0] pos;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_pos  = 0;

    stepper_move_ctrl #(.PHASES(9), .CNT_W(8), .DIV_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .dir_i        (dir),
        .steps_i      (steps),
        .div_i        (div),
        .abort_i      (abort),
        .busy_o       (busy),
        .done_o       (done),
        .step_pulse_o (step_pulse),
        .phase_o      (phase),
        .pos_o        (pos)
    );

    always #5 clk = ~clk;

    function automatic int wrap9(input int x);
        return ((x % 9) + 9) % 9;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ctx, input bit e_busy, input bit e_done,
                             input bit e_sp, input int e_pos);
        logic [31:0] e_phase;
        e_phase = 32'd1 << e_pos;
        check({ctx, ".busy"},  {31'd0, busy},       {31'd0, e_busy});
        check({ctx, ".done"},  {31'd0, done},       {31'd0, e_done});
        check({ctx, ".step"},  {31'd0, step_pulse}, {31'd0, e_sp});
        check({ctx, ".pos"},   {28'd0, pos},        32'(e_pos));
        check({ctx, ".phase"}, {23'd0, phase},      e_phase);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pos = 0;
    endtask

    // abort_k: cycle index (edges after accept) at which abort is sampled, 0 = none.
    task automatic do_move(input string ctx, input int n, input bit d, input int dv,
                           input int abort_k, input bit perturb);
        int p0, period, total, sgn, nst;
        p0     = exp_pos;
        period = dv + 1;
        total  = n * period;
        sgn    = d ? 1 : -1;
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        steps = 8'(n);
        div   = 8'(dv);
        abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            check({ctx, ".zero"}, 32'(busy), 32'd0);
            check_all({ctx, ".zero"}, 1'b0, 1'b1, 1'b0, p0);
            @(posedge clk); #1;
            check_all({ctx, ".zero_after"}, 1'b0, 1'b0, 1'b0, p0);
            return;
        end
        check_all({ctx, ".accept"}, 1'b1, 1'b0, 1'b0, p0);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            abort = (k == abort_k);
            if (perturb) begin
                start = 1'($urandom_range(0, 1));
                dir   = 1'($urandom_range(0, 1));
                div   = 8'($urandom_range(0, 255));
                steps = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            if (k == abort_k) begin
                start = 1'b0;
                abort = 1'b0;
                nst   = (k - 1) / period;
                check_all({ctx, ".abort"}, 1'b0, 1'b0, 1'b0, wrap9(p0 + sgn * nst));
                exp_pos = wrap9(p0 + sgn * nst);
                @(posedge clk); #1;
                check_all({ctx, ".post_abort"}, 1'b0, 1'b0, 1'b0, exp_pos);
                return;
            end
            nst = k / period;
            check_all(ctx, k < total, k == total, (k % period) == 0, wrap9(p0 + sgn * nst));
        end
        start = 1'b0;
        abort = 1'b0;
        exp_pos = wrap9(p0 + sgn * n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dv, ak;
        bit d, pert;
        rst   = 1'b1;
        start = 1'b0;
        dir   = 1'b0;
        abort = 1'b0;
        steps = 8'd0;
        div   = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (20) begin
            @(posedge clk); #1;
            check_all("idle", 1'b0, 1'b0, 1'b0, 0);
        end

        do_move("fwd10", 10, 1'b1, 0, 0, 1'b0);
        check("fwd10.final_phase", {23'd0, phase}, 32'h002);

        apply_reset();
        do_move("rev3", 3, 1'b0, 4, 0, 1'b0);
        check("rev3.final_phase", {23'd0, phase}, 32'h040);

        do_move("zero", 0, 1'b1, 3, 0, 1'b0);
        do_move("abort", 5, 1'b1, 2, 9, 1'b0);
        do_move("after_abort", 2, 1'b1, 0, 0, 1'b0);
        do_move("abort_last", 2, 1'b0, 1, 4, 1'b0);
        do_move("perturb", 6, 1'b1, 1, 0, 1'b1);

        // Reset in the middle of a move must act without waiting for an edge.
        @(negedge clk);
        start = 1'b1; dir = 1'b1; steps = 8'd20; div = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midrst.pos_before", {28'd0, pos}, 32'(wrap9(exp_pos + 3)));
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_all("midrst", 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_pos = 0;
        @(posedge clk); #1;
        check_all("midrst.after", 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            n    = $urandom_range(0, 12);
            dv   = $urandom_range(0, 5);
            d    = 1'($urandom_range(0, 1));
            pert = 1'($urandom_range(0, 1));
            ak   = 0;
            if (n != 0 && $urandom_range(0, 3) == 0) ak = $urandom_range(1, n * (dv + 1));
            do_move("rand", n, d, dv, ak, pert);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
